// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and decode helpers for the hazard/stall scheduler.
//   - opcode constants for the decode stage
//   - state_t: scheduler FSM encoding (RUN/STALL/FLUSH)
//   - shadow_entry_t: one in-flight destination record {valid, rd}
//   - uses_rs1/uses_rs2/writes_rd: per-opcode register usage
package hazard_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_BE  = 4'b0100;
  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  // Shadow entries carry rd at this fixed width; narrower register
  // addresses are zero-extended so the struct stays parameter-independent.
  localparam int unsigned RD_MAX_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
  } shadow_entry_t;

  function automatic logic uses_rs1(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_BE) || (op == OP_STR) || (op == OP_LDR);
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_BE) || (op == OP_STR);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_LDR);
  endfunction

endpackage

// File: rtl/hazard_stall_scheduler_shadow_regs.sv
// hazard_shadow_regs: registered shadow of in-flight destination registers
// (EX, MEM, WB) plus the RAW compare against the decode sources.
//   clk, rst      : clock, synchronous active-low reset (clears all entries)
//   new_valid/rd  : entry shifted into EX this cycle
//   rs1/rs2       : decode sources; use_rs1/use_rs2 qualify them
//   hazard        : a used source matches a valid compared entry
// With HAZARD_WB_SPLIT_EN defined the register file writes in the first
// half-cycle, so the WB entry is never compared and is not stored at all.
module hazard_shadow_regs
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_valid,
  input  logic [REG_ADDR_W-1:0] new_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  output logic                  hazard
);

  shadow_entry_t ex_q, mem_q;
  shadow_entry_t new_entry;
  logic [RD_MAX_W-1:0] rs1_ext, rs2_ext;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = new_valid;
    new_entry.rd    = new_valid ? RD_MAX_W'(new_rd) : '0;
    rs1_ext         = RD_MAX_W'(rs1);
    rs2_ext         = RD_MAX_W'(rs2);
  end

  function automatic logic hit(input shadow_entry_t e,
                               input logic [RD_MAX_W-1:0] s1,
                               input logic [RD_MAX_W-1:0] s2,
                               input logic u1, input logic u2);
    return e.valid && ((u1 && (e.rd == s1)) || (u2 && (e.rd == s2)));
  endfunction

`ifdef HAZARD_WB_SPLIT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= new_entry;
      mem_q <= ex_q;
    end
  end

  always_comb begin
    hazard = hit(ex_q,  rs1_ext, rs2_ext, use_rs1, use_rs2) ||
             hit(mem_q, rs1_ext, rs2_ext, use_rs1, use_rs2);
  end
`else
  shadow_entry_t wb_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= new_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_comb begin
    hazard = hit(ex_q,  rs1_ext, rs2_ext, use_rs1, use_rs2) ||
             hit(mem_q, rs1_ext, rs2_ext, use_rs1, use_rs2) ||
             hit(wb_q,  rs1_ext, rs2_ext, use_rs1, use_rs2);
  end
`endif

endmodule

// File: rtl/hazard_stall_scheduler.sv
// hazard_stall_scheduler: decides each cycle whether the decoded instruction
// issues, stalls on a RAW hazard, or is squashed after a taken BE.
//   clk, rst            : clock, synchronous active-low reset
//   id_opcode/rs1/rs2/rd: decode-stage instruction fields
//   ex_branch_taken     : BE in EX resolved taken
//   stall_pc/stall_ifid : hold PC and IF/ID
//   flush_ifid          : load nop into IF/ID
//   bubble_idex         : stall-mux select, forces a zero control word
//   state               : FSM state (debug)
//   stall_count/flush_count : saturating statistics
// Optional macro HAZARD_WB_SPLIT_EN: exclude the WB entry from the compare.
module hazard_stall_scheduler
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             id_opcode,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   ex_branch_taken,
  output logic                   stall_pc,
  output logic                   stall_ifid,
  output logic                   flush_ifid,
  output logic                   bubble_idex,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [STALL_CNT_W-1:0] flush_count
);

  state_t                 state_q, state_d;
  logic [1:0]             flush_cnt_q, flush_cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q, flush_count_q;
  logic                   hazard;
  logic                   issue;

  hazard_shadow_regs #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .new_valid (issue && writes_rd(id_opcode)),
    .new_rd    (id_rd),
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .use_rs1   (uses_rs1(id_opcode)),
    .use_rs2   (uses_rs2(id_opcode)),
    .hazard    (hazard)
  );

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    issue       = 1'b0;
    state_d     = RUN;
    flush_cnt_d = flush_cnt_q;
    if (ex_branch_taken) begin
      // A taken branch squashes decode even if it was stalled; a branch
      // arriving during FLUSH simply reloads the counter.
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      flush_cnt_d = 2'(FLUSH_CYCLES);
      state_d     = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      flush_cnt_d = (flush_cnt_q == 2'd0) ? 2'd0 : flush_cnt_q - 2'd1;
      state_d     = (flush_cnt_q <= 2'd1) ? RUN : FLUSH;
    end else if (hazard) begin
      // Covers RUN, STALL and the illegal encoding, which recovers via RUN.
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
      state_d     = STALL;
    end else begin
      issue = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (stall_pc && (stall_count_q != '1))
        stall_count_q <= stall_count_q + STALL_CNT_W'(1);
      if (flush_ifid && (flush_count_q != '1))
        flush_count_q <= flush_count_q + STALL_CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_scheduler.sv
module tb_hazard_stall_scheduler;

`ifdef HAZARD_WB_SPLIT_EN
  localparam int unsigned STALL_LEN = 2;
`else
  localparam int unsigned STALL_LEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  id_opcode = 4'h0;
  logic [3:0]  id_rs1 = 4'h0, id_rs2 = 4'h0, id_rd = 4'h0;
  logic        ex_branch_taken = 1'b0;

  logic        stall_pc, stall_ifid, flush_ifid, bubble_idex;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;

  logic        s_stall_pc, s_stall_ifid, s_flush_ifid, s_bubble_idex;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_count, s_flush_count;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  hazard_stall_scheduler #(
    .REG_ADDR_W   (4),
    .FLUSH_CYCLES (1),
    .STALL_CNT_W  (16)
  ) u_dut (
    .clk (clk), .rst (rst), .id_opcode (id_opcode), .id_rs1 (id_rs1),
    .id_rs2 (id_rs2), .id_rd (id_rd), .ex_branch_taken (ex_branch_taken),
    .stall_pc (stall_pc), .stall_ifid (stall_ifid), .flush_ifid (flush_ifid),
    .bubble_idex (bubble_idex), .state (state),
    .stall_count (stall_count), .flush_count (flush_count)
  );

  // Narrow-counter instance on the same stimulus, for saturation.
  hazard_stall_scheduler #(
    .REG_ADDR_W   (4),
    .FLUSH_CYCLES (1),
    .STALL_CNT_W  (2)
  ) u_dut_sat (
    .clk (clk), .rst (rst), .id_opcode (id_opcode), .id_rs1 (id_rs1),
    .id_rs2 (id_rs2), .id_rd (id_rd), .ex_branch_taken (ex_branch_taken),
    .stall_pc (s_stall_pc), .stall_ifid (s_stall_ifid), .flush_ifid (s_flush_ifid),
    .bubble_idex (s_bubble_idex), .state (s_state),
    .stall_count (s_stall_count), .flush_count (s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one decode vector at the falling edge, settle, leave sampling to caller.
  task automatic drive(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic br);
    @(negedge clk);
    id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; ex_branch_taken = br;
    #1;
  endtask

  // Packed {stall_pc, stall_ifid, flush_ifid, bubble_idex}
  function automatic logic [3:0] ctrl();
    return {stall_pc, stall_ifid, flush_ifid, bubble_idex};
  endfunction

  task automatic drain();
    for (int i = 0; i < 3; i++) drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  function automatic int unsigned sat3(input int unsigned v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    // Reset
    rst = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("reset_ctrl", 32'(ctrl()), 32'h0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall_cnt", 32'(stall_count), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);

    // add r1 ; add r2 <- r1
    drive(4'b0001, 4'd0, 4'd0, 4'd1, 1'b0);
    chk("add_r1_issue", 32'(ctrl()), 32'h0);
    for (int i = 0; i < int'(STALL_LEN); i++) begin
      drive(4'b0001, 4'd1, 4'd5, 4'd2, 1'b0);
      chk("raw_add_stall", 32'(ctrl()), 32'b1101);
      if (i == 1) chk("raw_add_state", 32'(state), 32'd1);
    end
    drive(4'b0001, 4'd1, 4'd5, 4'd2, 1'b0);
    chk("raw_add_release", 32'(ctrl()), 32'h0);
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("raw_add_count", 32'(stall_count), 32'(STALL_LEN));
    chk("raw_add_state_run", 32'(state), 32'd0);
    drain();

    // ldr r3 ; str data=r3
    drive(4'b1001, 4'd0, 4'd0, 4'd3, 1'b0);
    chk("ldr_issue", 32'(ctrl()), 32'h0);
    for (int i = 0; i < int'(STALL_LEN); i++) begin
      drive(4'b1010, 4'd0, 4'd3, 4'd0, 1'b0);
      chk("str_rs2_stall", 32'(stall_pc), 32'd1);
    end
    drive(4'b1010, 4'd0, 4'd3, 4'd0, 1'b0);
    chk("str_rs2_release", 32'(stall_pc), 32'd0);
    drain();

    // ldr r3 ; str base=r3
    drive(4'b1001, 4'd0, 4'd0, 4'd3, 1'b0);
    for (int i = 0; i < int'(STALL_LEN); i++) begin
      drive(4'b1010, 4'd3, 4'd0, 4'd0, 1'b0);
      chk("str_rs1_stall", 32'(stall_ifid), 32'd1);
    end
    drive(4'b1010, 4'd3, 4'd0, 4'd0, 1'b0);
    chk("str_rs1_release", 32'(stall_ifid), 32'd0);
    drain();
    chk("stall_cnt_total", 32'(stall_count), 32'(3 * STALL_LEN));
    chk("stall_cnt_saturated", 32'(s_stall_count), 32'(sat3(3 * STALL_LEN)));

    // ldr r3 ; ldr rs1=r4 -> independent
    drive(4'b1001, 4'd0, 4'd0, 4'd3, 1'b0);
    drive(4'b1001, 4'd4, 4'd3, 4'd5, 1'b0);
    chk("ldr_ldr_no_stall", 32'(ctrl()), 32'h0);
    drain();

    // add r6 ; taken BE in EX while dependent add in decode
    drive(4'b0001, 4'd0, 4'd0, 4'd6, 1'b0);
    drive(4'b0001, 4'd6, 4'd0, 4'd7, 1'b1);
    chk("branch_ctrl", 32'(ctrl()), 32'b0011);
    drive(4'b0001, 4'd6, 4'd0, 4'd7, 1'b0);
    chk("flush_hold_ctrl", 32'(ctrl()), 32'b0011);
    chk("flush_hold_state", 32'(state), 32'd2);
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("flush_done_ctrl", 32'(ctrl()), 32'h0);
    chk("flush_done_state", 32'(state), 32'd0);
    chk("flush_count", 32'(flush_count), 32'd2);
    chk("flush_no_stall_cnt", 32'(stall_count), 32'(3 * STALL_LEN));
    drain();

    // Undefined opcode is a nop: no stall, no shadow entry
    drive(4'b0001, 4'd0, 4'd0, 4'd8, 1'b0);
    drive(4'b1111, 4'd8, 4'd8, 4'd9, 1'b0);
    chk("undef_op_no_stall", 32'(ctrl()), 32'h0);
    drive(4'b0001, 4'd9, 4'd0, 4'd10, 1'b0);
    chk("undef_op_no_entry", 32'(ctrl()), 32'h0);
    drain();

    // Reset during the second stall cycle
    drive(4'b0001, 4'd0, 4'd0, 4'd11, 1'b0);
    drive(4'b0001, 4'd11, 4'd0, 4'd12, 1'b0);
    chk("pre_reset_stall1", 32'(ctrl()), 32'b1101);
    drive(4'b0001, 4'd11, 4'd0, 4'd12, 1'b0);
    rst = 1'b0;
    chk("pre_reset_stall2", 32'(ctrl()), 32'b1101);
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("post_reset_ctrl", 32'(ctrl()), 32'h0);
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_stall_cnt", 32'(stall_count), 32'd0);
    chk("post_reset_flush_cnt", 32'(flush_count), 32'd0);
    chk("post_reset_sat_cnt", 32'(s_stall_count), 32'd0);
    drive(4'b0001, 4'd11, 4'd0, 4'd12, 1'b0);
    chk("post_reset_shadow_empty", 32'(ctrl()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
